// File: rtl/lvt_ram_2w2r_if.sv
// rtl/lvt_ram_2w2r_if.sv - port bundle for the two-write two-read LVT memory
interface lvt_ram_2w2r_if #(
    parameter int BLOCLSIZE = 7,
    parameter int DATA_W    = 32
);
    logic [BLOCLSIZE:0]  w_addr_1;
    logic [DATA_W-1:0]   w_din_1;
    logic                w_enb_1;
    logic [BLOCLSIZE:0]  w_addr_2;
    logic [DATA_W-1:0]   w_din_2;
    logic                w_enb_2;
    logic [BLOCLSIZE:0]  r_addr_1;
    logic [DATA_W-1:0]   r_dout_1;
    logic [BLOCLSIZE:0]  r_addr_2;
    logic [DATA_W-1:0]   r_dout_2;
    logic                ready;

    modport master (
        output w_addr_1, w_din_1, w_enb_1,
        output w_addr_2, w_din_2, w_enb_2,
        output r_addr_1, r_addr_2,
        input  r_dout_1, r_dout_2, ready
    );

    modport slave (
        input  w_addr_1, w_din_1, w_enb_1,
        input  w_addr_2, w_din_2, w_enb_2,
        input  r_addr_1, r_addr_2,
        output r_dout_1, r_dout_2, ready
    );
endinterface

// File: rtl/lvt_ram_2w2r.sv
// rtl/lvt_ram_2w2r.sv - 2W2R memory from replicated 1R1W banks steered by a live value table
module lvt_ram_2w2r #(
    parameter int BLOCLSIZE = 7,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    lvt_ram_2w2r_if.slave     bus
);
    localparam int ADDR_W = BLOCLSIZE + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]    lvt_q, lvt_d;

    logic                in_init, in_run;

    // Bank naming: bank_w<writer>_r<reader>
    logic [DATA_W-1:0]   bank_w1_r1 [DEPTH];
    logic [DATA_W-1:0]   bank_w1_r2 [DEPTH];
    logic [DATA_W-1:0]   bank_w2_r1 [DEPTH];
    logic [DATA_W-1:0]   bank_w2_r2 [DEPTH];

    logic                wr1_en, wr2_en;
    logic [ADDR_W-1:0]   wr1_addr, wr2_addr;
    logic [DATA_W-1:0]   wr1_data, wr2_data;

    logic [DATA_W-1:0]   rd_w1_r1_q, rd_w2_r1_q, rd_w1_r2_q, rd_w2_r2_q;
    logic                sel_r1_q, sel_r2_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = S_RUN;
            end
        end
    end

    // Output decode
    always_comb begin
        in_init   = (state_q == S_INIT);
        in_run    = (state_q == S_RUN);
        bus.ready = in_run;
    end

    // Sweep zeros through every bank during INIT, otherwise take the live write ports
    always_comb begin
        wr1_en   = in_init | (in_run & bus.w_enb_1);
        wr2_en   = in_init | (in_run & bus.w_enb_2);
        wr1_addr = in_init ? cnt_q : bus.w_addr_1;
        wr2_addr = in_init ? cnt_q : bus.w_addr_2;
        wr1_data = in_init ? '0 : bus.w_din_1;
        wr2_data = in_init ? '0 : bus.w_din_2;
    end

    always_ff @(posedge clk) begin
        if (wr1_en) begin
            bank_w1_r1[wr1_addr] <= wr1_data;
            bank_w1_r2[wr1_addr] <= wr1_data;
        end
        if (wr2_en) begin
            bank_w2_r1[wr2_addr] <= wr2_data;
            bank_w2_r2[wr2_addr] <= wr2_data;
        end
    end

    // Port 2 update is applied last so it wins a same-address conflict
    always_comb begin
        lvt_d = lvt_q;
        if (in_run && bus.w_enb_1) begin
            lvt_d[bus.w_addr_1] = 1'b0;
        end
        if (in_run && bus.w_enb_2) begin
            lvt_d[bus.w_addr_2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvt_q <= '0;
        end else begin
            lvt_q <= lvt_d;
        end
    end

    // Read capture; INIT captures zero, which also covers the last sweep address on the RUN edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_w1_r1_q <= '0;
            rd_w2_r1_q <= '0;
            rd_w1_r2_q <= '0;
            rd_w2_r2_q <= '0;
            sel_r1_q   <= 1'b0;
            sel_r2_q   <= 1'b0;
        end else if (in_run) begin
            rd_w1_r1_q <= bank_w1_r1[bus.r_addr_1];
            rd_w2_r1_q <= bank_w2_r1[bus.r_addr_1];
            rd_w1_r2_q <= bank_w1_r2[bus.r_addr_2];
            rd_w2_r2_q <= bank_w2_r2[bus.r_addr_2];
            sel_r1_q   <= lvt_q[bus.r_addr_1];
            sel_r2_q   <= lvt_q[bus.r_addr_2];
        end else begin
            rd_w1_r1_q <= '0;
            rd_w2_r1_q <= '0;
            rd_w1_r2_q <= '0;
            rd_w2_r2_q <= '0;
            sel_r1_q   <= 1'b0;
            sel_r2_q   <= 1'b0;
        end
    end

    always_comb begin
        bus.r_dout_1 = sel_r1_q ? rd_w2_r1_q : rd_w1_r1_q;
        bus.r_dout_2 = sel_r2_q ? rd_w2_r2_q : rd_w1_r2_q;
    end
endmodule

// File: tb/tb_lvt_ram_2w2r.sv
// tb/tb_lvt_ram_2w2r.sv - randomized self-checking bench for lvt_ram_2w2r
module tb_lvt_ram_2w2r;
    localparam int DEPTH = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] ref_mem [DEPTH];

    lvt_ram_2w2r_if #(.BLOCLSIZE(7), .DATA_W(32)) bus ();

    lvt_ram_2w2r #(.BLOCLSIZE(7), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.w_enb_1  = 1'b0;
        bus.w_enb_2  = 1'b0;
        bus.w_addr_1 = '0;
        bus.w_addr_2 = '0;
        bus.w_din_1  = '0;
        bus.w_din_2  = '0;
    endtask

    // Reference: read returns pre-edge contents, then port 1 then port 2 writes land
    task automatic tick(output logic [31:0] e1, output logic [31:0] e2);
        e1 = ref_mem[bus.r_addr_1];
        e2 = ref_mem[bus.r_addr_2];
        if (bus.w_enb_1) ref_mem[bus.w_addr_1] = bus.w_din_1;
        if (bus.w_enb_2) ref_mem[bus.w_addr_2] = bus.w_din_2;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (bus.ready !== 1'b1 && n < 400) begin
            bus.w_enb_1  = $urandom_range(0, 1);
            bus.w_enb_2  = $urandom_range(0, 1);
            bus.w_addr_1 = 8'($urandom);
            bus.w_addr_2 = 8'($urandom);
            bus.w_din_1  = $urandom;
            bus.w_din_2  = $urandom;
            bus.r_addr_1 = 8'($urandom);
            bus.r_addr_2 = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.ready !== 1'b1 && (bus.r_dout_1 !== 32'h0 || bus.r_dout_2 !== 32'h0)) bad++;
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL %s init_len got %0d want 256", name, n);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s dout_during_init nonzero_cycles %0d want 0", name, bad);
        end
        checks++;
        if (bus.r_dout_1 !== 32'h0 || bus.r_dout_2 !== 32'h0) begin
            errors++;
            $display("FAIL %s first_run_read got %h %h want 0 0", name, bus.r_dout_1, bus.r_dout_2);
        end
    endtask

    task automatic test_reset();
        logic [31:0] e1, e2;
        idle_inputs();
        bus.r_addr_1 = '0;
        bus.r_addr_2 = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0 || bus.r_dout_1 !== 32'h0 || bus.r_dout_2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state ready %b dout %h %h want 0 0 0", bus.ready, bus.r_dout_1, bus.r_dout_2);
        end
        rst = 1'b1;
        wait_ready("reset");
        for (int i = 0; i < 8; i++) begin
            bus.r_addr_1 = 8'($urandom);
            bus.r_addr_2 = 8'($urandom);
            tick(e1, e2);
            checks++;
            if (bus.r_dout_1 !== e1 || bus.r_dout_2 !== e2) begin
                errors++;
                $display("FAIL post_init_read got %h %h want %h %h", bus.r_dout_1, bus.r_dout_2, e1, e2);
            end
        end
    endtask

    task automatic wr(input int port, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] e1, e2;
        idle_inputs();
        if (port == 1) begin
            bus.w_enb_1 = 1'b1; bus.w_addr_1 = a; bus.w_din_1 = d;
        end else begin
            bus.w_enb_2 = 1'b1; bus.w_addr_2 = a; bus.w_din_2 = d;
        end
        tick(e1, e2);
        idle_inputs();
    endtask

    task automatic rd_check(input string name, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] e1, e2;
        bus.r_addr_1 = a1;
        bus.r_addr_2 = a2;
        tick(e1, e2);
        checks++;
        if (bus.r_dout_1 !== w1 || bus.r_dout_2 !== w2) begin
            errors++;
            $display("FAIL %s got %h %h want %h %h", name, bus.r_dout_1, bus.r_dout_2, w1, w2);
        end
    endtask

    task automatic test_basic();
        wr(1, 8'h05, 32'h1111_1111);
        rd_check("basic_write", 8'h05, 8'h05, 32'h1111_1111, 32'h1111_1111);
        wr(1, 8'h10, 32'hAAAA_0001);
        rd_check("last_writer_p1", 8'h10, 8'h10, 32'hAAAA_0001, 32'hAAAA_0001);
        wr(2, 8'h10, 32'hBBBB_0002);
        rd_check("last_writer_p2", 8'h10, 8'h10, 32'hBBBB_0002, 32'hBBBB_0002);
        wr(1, 8'h10, 32'hCCCC_0003);
        rd_check("last_writer_back_p1", 8'h10, 8'h10, 32'hCCCC_0003, 32'hCCCC_0003);
    endtask

    task automatic test_conflict();
        logic [31:0] e1, e2;
        bus.w_enb_1 = 1'b1; bus.w_addr_1 = 8'h20; bus.w_din_1 = 32'h1;
        bus.w_enb_2 = 1'b1; bus.w_addr_2 = 8'h20; bus.w_din_2 = 32'h2;
        tick(e1, e2);
        bus.w_enb_1 = 1'b1; bus.w_addr_1 = 8'h21; bus.w_din_1 = 32'h3;
        bus.w_enb_2 = 1'b1; bus.w_addr_2 = 8'h22; bus.w_din_2 = 32'h4;
        tick(e1, e2);
        idle_inputs();
        rd_check("conflict_p2_wins", 8'h20, 8'h20, 32'h2, 32'h2);
        rd_check("dual_distinct", 8'h21, 8'h22, 32'h3, 32'h4);
    endtask

    task automatic test_rdw();
        logic [31:0] e1, e2;
        wr(1, 8'h30, 32'h5);
        bus.w_enb_2 = 1'b1; bus.w_addr_2 = 8'h30; bus.w_din_2 = 32'h6;
        bus.r_addr_1 = 8'h30;
        bus.r_addr_2 = 8'h30;
        tick(e1, e2);
        idle_inputs();
        checks++;
        if (bus.r_dout_1 !== 32'h5 || bus.r_dout_2 !== 32'h5) begin
            errors++;
            $display("FAIL rdw_old got %h %h want 00000005", bus.r_dout_1, bus.r_dout_2);
        end
        rd_check("rdw_new", 8'h30, 8'h30, 32'h6, 32'h6);
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            bus.w_enb_1  = $urandom_range(0, 1);
            bus.w_enb_2  = $urandom_range(0, 1);
            bus.w_addr_1 = 8'($urandom_range(0, 15));
            bus.w_addr_2 = 8'($urandom_range(0, 15));
            bus.w_din_1  = $urandom;
            bus.w_din_2  = $urandom;
            bus.r_addr_1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            bus.r_addr_2 = 8'($urandom_range(0, 15));
            tick(e1, e2);
            if (bus.r_dout_1 !== e1 || bus.r_dout_2 !== e2) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle %0d got %h %h want %h %h", i, bus.r_dout_1, bus.r_dout_2, e1, e2);
            end
        end
        idle_inputs();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL random_total bad_cycles %0d want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        wr(1, 8'hFF, 32'hDEAD_BEEF);
        rd_check("pre_reset_ff", 8'hFF, 8'hFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        bus.r_addr_1 = 8'hFF;
        bus.r_addr_2 = 8'hFF;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0 || bus.r_dout_1 !== 32'h0 || bus.r_dout_2 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_async ready %b dout %h %h want 0 0 0", bus.ready, bus.r_dout_1, bus.r_dout_2);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_ready("mid_reset");
        rd_check("after_reset_ff", 8'hFF, 8'h10, 32'h0, 32'h0);
        rd_check("after_reset_other", 8'h05, 8'h20, 32'h0, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        idle_inputs();
        bus.r_addr_1 = '0;
        bus.r_addr_2 = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_conflict();
        test_rdw();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
